// File: rtl/noc_vc_split_pkg.sv
// Shared parameters and types for the multi-VC link receive endpoint.
// Holds the link geometry (VC count, flit width, per-VC FIFO depth), the
// flit type encoding carried in the top two flit bits, and the state type
// of the optional per-VC packet checker (NOC_VC_SPLIT_PKT_CHECK_EN).
package noc_vc_split_pkg;

   localparam int Noc_VC_Channel    = 4;
   localparam int Noc_Data_Width    = 8;
   localparam int Noc_VC_Fifo_Depth = 4;
   localparam int Noc_Flit_Type_Msb = Noc_Data_Width - 1;

   typedef enum logic [1:0] {
      HEAD   = 2'b00,
      BODY   = 2'b01,
      TAIL   = 2'b10,
      SINGLE = 2'b11
   } Noc_flit_type_e;

   typedef enum logic {
      CHK_IDLE   = 1'b0,
      CHK_IN_PKT = 1'b1
   } noc_chk_state_e;

endpackage

// File: rtl/noc_vc_split_fifo.sv
// Single-VC first-word-fall-through FIFO.
// Ports:
//   noc_clk, noc_rst   clock, synchronous active-high reset
//   i_clear            synchronous flush (pointers and count to 0)
//   i_push, i_data     write request and data
//   i_pop              pop request, honoured only while o_valid
//   o_valid, o_data    head entry valid and data
//   o_count, o_full    current occupancy and full flag
module noc_vc_split_fifo
   import noc_vc_split_pkg::*;
#(
   parameter int WIDTH = Noc_Data_Width,
   parameter int DEPTH = Noc_VC_Fifo_Depth,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             noc_clk,
   input  logic             noc_rst,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_valid = (r_count != '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && o_valid;

   always_ff @(posedge noc_clk) begin
      if (noc_rst || i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are never visible because
   // o_valid is derived from the count.
   always_ff @(posedge noc_clk) begin
      if (w_push && !noc_rst && !i_clear) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/noc_vc_split.sv
// Receive-side endpoint of a multi-VC link. Steers the shared link flit
// into one FWFT FIFO per VC and returns per-VC ready / almost-full hints.
// Optional packet-framing checker enabled by macro NOC_VC_SPLIT_PKT_CHECK_EN.
// Ports:
//   noc_clk, noc_rst   clock, synchronous active-high reset
//   i_clear            flush all FIFOs (and checker state / errors)
//   i_valid, i_flit    per-VC valid (one-hot0 expected), shared flit
//   o_ready            per-VC accept, o_vc_ready per-VC occupancy < THRESHOLD
//   o_valid, o_flit    per-VC FIFO head, i_ready per-VC pop
//   o_err              sticky per-VC protocol error (0 without the checker)
//
// Checker FSM (per VC):
//   state      | meaning
//   CHK_IDLE   | between packets; expects HEAD or SINGLE
//   CHK_IN_PKT | inside a packet; expects BODY or TAIL
module noc_vc_split
   import noc_vc_split_pkg::*;
#(
   parameter int CHANNELS  = Noc_VC_Channel,
   parameter int DEPTH     = Noc_VC_Fifo_Depth,
   parameter int THRESHOLD = Noc_VC_Fifo_Depth - 2
) (
   input  logic                                     noc_clk,
   input  logic                                     noc_rst,
   input  logic                                     i_clear,
   input  logic [CHANNELS-1:0]                      i_valid,
   input  logic [Noc_Data_Width-1:0]                i_flit,
   output logic [CHANNELS-1:0]                      o_ready,
   output logic [CHANNELS-1:0]                      o_vc_ready,
   output logic [CHANNELS-1:0]                      o_valid,
   output logic [CHANNELS-1:0][Noc_Data_Width-1:0] o_flit,
   input  logic [CHANNELS-1:0]                      i_ready,
   output logic [CHANNELS-1:0]                      o_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CHANNELS-1:0] w_sel_onehot;
   logic [CHANNELS-1:0] w_accept_mask;
   logic [CHANNELS-1:0] w_full;
   logic [CHANNELS-1:0] w_push;
   logic [CW-1:0]       w_count [CHANNELS];

   // Two's-complement trick isolates the lowest set valid bit.
   assign w_sel_onehot = i_valid & (~i_valid + CHANNELS'(1));
   // With nothing offered every non-full VC advertises ready.
   assign w_accept_mask = (i_valid == '0) ? '1 : w_sel_onehot;
   assign o_ready       = noc_rst ? '0 : (~w_full & w_accept_mask);
   assign w_push        = i_valid & o_ready;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_vc
      noc_vc_split_fifo #(
         .WIDTH (Noc_Data_Width),
         .DEPTH (DEPTH)
      ) u_fifo (
         .noc_clk (noc_clk),
         .noc_rst (noc_rst),
         .i_clear (i_clear),
         .i_push  (w_push[g]),
         .i_data  (i_flit),
         .i_pop   (i_ready[g]),
         .o_valid (o_valid[g]),
         .o_data  (o_flit[g]),
         .o_count (w_count[g]),
         .o_full  (w_full[g])
      );

      assign o_vc_ready[g] = !noc_rst && (w_count[g] < CW'(THRESHOLD));
   end

`ifdef NOC_VC_SPLIT_PKT_CHECK_EN
   noc_chk_state_e r_state     [CHANNELS];
   noc_chk_state_e w_state_nxt [CHANNELS];
   logic [CHANNELS-1:0] r_err;
   logic [CHANNELS-1:0] w_err_set;
   Noc_flit_type_e      w_type;

   assign w_type = Noc_flit_type_e'(i_flit[Noc_Flit_Type_Msb -: 2]);

   always_ff @(posedge noc_clk) begin
      if (noc_rst || i_clear) begin
         for (int i = 0; i < CHANNELS; i++) r_state[i] <= CHK_IDLE;
         r_err <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) r_state[i] <= w_state_nxt[i];
         r_err <= r_err | w_err_set;
      end
   end

   always_comb begin
      // Every offered VC other than the selected one is a protocol violation.
      w_err_set = i_valid & ~w_sel_onehot;
      for (int i = 0; i < CHANNELS; i++) begin
         w_state_nxt[i] = r_state[i];
         if (w_push[i]) begin
            case (r_state[i])
               CHK_IDLE: begin
                  case (w_type)
                     HEAD:    w_state_nxt[i] = CHK_IN_PKT;
                     SINGLE:  w_state_nxt[i] = CHK_IDLE;
                     default: w_err_set[i]   = 1'b1;
                  endcase
               end
               CHK_IN_PKT: begin
                  case (w_type)
                     BODY:    w_state_nxt[i] = CHK_IN_PKT;
                     TAIL:    w_state_nxt[i] = CHK_IDLE;
                     HEAD: begin
                        w_err_set[i]   = 1'b1;
                        w_state_nxt[i] = CHK_IN_PKT;
                     end
                     default: begin
                        w_err_set[i]   = 1'b1;
                        w_state_nxt[i] = CHK_IDLE;
                     end
                  endcase
               end
               default: w_state_nxt[i] = CHK_IDLE;
            endcase
         end
      end
   end

   assign o_err = r_err;
`else
   assign o_err = '0;
`endif

endmodule
